// File: rtl/alu_pkg.sv
// Shared opcodes, widths, flag positions and FSM states for the ALU issue arbiter.
package alu_pkg;

  localparam int unsigned OP_W   = 4;
  localparam int unsigned FLAG_W = 5;
  localparam int unsigned DATA_W = 32;

  localparam logic [OP_W-1:0] OP_ADD  = 4'd0;
  localparam logic [OP_W-1:0] OP_SUB  = 4'd1;
  localparam logic [OP_W-1:0] OP_SL   = 4'd2;
  localparam logic [OP_W-1:0] OP_SR   = 4'd3;
  localparam logic [OP_W-1:0] OP_AND  = 4'd4;
  localparam logic [OP_W-1:0] OP_OR   = 4'd5;
  localparam logic [OP_W-1:0] OP_XOR  = 4'd6;
  localparam logic [OP_W-1:0] OP_NAND = 4'd7;
  localparam logic [OP_W-1:0] OP_NOT  = 4'd8;
  localparam logic [OP_W-1:0] OP_NOR  = 4'd9;

  localparam int unsigned ZF = 4;
  localparam int unsigned NF = 3;
  localparam int unsigned EF = 2;
  localparam int unsigned GF = 1;
  localparam int unsigned LF = 0;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StResp
  } state_e;

endpackage

// File: rtl/alu_core.sv
// Shared combinational integer ALU; unknown opcodes yield zero and raise err_o.
module alu_core
  import alu_pkg::*;
(
  input  logic [OP_W-1:0]   op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] result_o,
  output logic [FLAG_W-1:0] flags_o,
  output logic              err_o
);

  always_comb begin
    result_o = '0;
    err_o    = 1'b0;
    case (op_i)
      OP_ADD:  result_o = a_i + b_i;
      OP_SUB:  result_o = a_i - b_i;
      // Full 32-bit unsigned shift amount: anything >= 32 clears the result.
      OP_SL:   result_o = a_i << b_i;
      OP_SR:   result_o = a_i >> b_i;
      OP_AND:  result_o = a_i & b_i;
      OP_OR:   result_o = a_i | b_i;
      OP_XOR:  result_o = a_i ^ b_i;
      OP_NAND: result_o = ~(a_i & b_i);
      OP_NOT:  result_o = ~a_i;
      OP_NOR:  result_o = ~(a_i | b_i);
      default: err_o    = 1'b1;
    endcase
  end

  always_comb begin
    flags_o     = '0;
    flags_o[ZF] = (result_o == '0);
    flags_o[NF] = result_o[DATA_W-1];
    flags_o[EF] = (result_o == a_i);
    flags_o[GF] = ($signed(a_i) > $signed(b_i));
    flags_o[LF] = ($signed(a_i) < $signed(b_i));
  end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first valid requester at or after ptr_i, wrapping.
module rr_arbiter #(
  parameter int unsigned NumReq = 4,
  parameter int unsigned IdW    = 2
) (
  input  logic [NumReq-1:0] valid_i,
  input  logic [IdW-1:0]    ptr_i,
  output logic [NumReq-1:0] grant_o,
  output logic [IdW-1:0]    idx_o,
  output logic              any_o
);

  logic [IdW-1:0] cand;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    cand    = '0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      cand = IdW'((32'(ptr_i) + k) % NumReq);
      if (!any_o && valid_i[cand]) begin
        any_o         = 1'b1;
        idx_o         = cand;
        grant_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_issue_arbiter.sv
// Round-robin issue controller sharing one ALU among NUM_REQ requesters, with a
// single tagged, backpressured response channel.
module alu_issue_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [OP_W*NUM_REQ-1:0]   req_op,
  input  logic [DATA_W*NUM_REQ-1:0] req_a,
  input  logic [DATA_W*NUM_REQ-1:0] req_b,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_result,
  output logic [FLAG_W-1:0]         rsp_flags,
  output logic                      rsp_err,
  output logic                      busy
);

  state_e state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [OP_W-1:0]   op_q;
  logic [DATA_W-1:0] a_q, b_q;
  logic [ID_W-1:0]   id_q;
  logic              rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]   rsp_id_q;
  logic [DATA_W-1:0] rsp_result_q;
  logic [FLAG_W-1:0] rsp_flags_q;
  logic              rsp_err_q;

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    win_idx;
  logic               any_valid;
  logic               load_op;
  logic               capture_rsp;
  logic [OP_W-1:0]    win_op;
  logic [DATA_W-1:0]  win_a, win_b;
  logic [DATA_W-1:0]  alu_result;
  logic [FLAG_W-1:0]  alu_flags;
  logic               alu_err;

  rr_arbiter #(
    .NumReq (NUM_REQ),
    .IdW    (ID_W)
  ) u_rr_arbiter (
    .valid_i (req_valid),
    .ptr_i   (rr_ptr_q),
    .grant_o (grant),
    .idx_o   (win_idx),
    .any_o   (any_valid)
  );

  assign win_op = req_op[32'(win_idx)*OP_W +: OP_W];
  assign win_a  = req_a[32'(win_idx)*DATA_W +: DATA_W];
  assign win_b  = req_b[32'(win_idx)*DATA_W +: DATA_W];

  // Fed only from the operand registers so the ALU never sees live requester buses.
  alu_core u_alu_core (
    .op_i     (op_q),
    .a_i      (a_q),
    .b_i      (b_q),
    .result_o (alu_result),
    .flags_o  (alu_flags),
    .err_o    (alu_err)
  );

  always_comb begin
    state_d     = state_q;
    rsp_valid_d = rsp_valid_q;
    req_ready   = '0;
    load_op     = 1'b0;
    capture_rsp = 1'b0;
    // No grant may be issued while reset is asserted.
    if (!rst) begin
      case (state_q)
        StIdle: begin
          if (any_valid) begin
            req_ready = grant;
            load_op   = 1'b1;
            state_d   = StExec;
          end
        end
        StExec: begin
          capture_rsp = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = StResp;
        end
        StResp: begin
          if (rsp_ready) begin
            rsp_valid_d = 1'b0;
            if (any_valid) begin
              req_ready = grant;
              load_op   = 1'b1;
              state_d   = StExec;
            end else begin
              state_d = StIdle;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (load_op) begin
      rr_ptr_d = (32'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + ID_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      rr_ptr_q     <= '0;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      id_q         <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      rsp_valid_q <= rsp_valid_d;
      if (load_op) begin
        op_q <= win_op;
        a_q  <= win_a;
        b_q  <= win_b;
        id_q <= win_idx;
      end
      if (capture_rsp) begin
        rsp_id_q     <= id_q;
        rsp_result_q <= alu_result;
        rsp_flags_q  <= alu_flags;
        rsp_err_q    <= alu_err;
      end
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flags  = rsp_flags_q;
  assign rsp_err    = rsp_err_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: doc/alu_issue_arbiter.md
# alu_issue_arbiter

Round-robin issue controller that shares one combinational ALU instance among `NUM_REQ` requesters (shader lanes / warp slots). It accepts operation requests over per-requester valid/ready handshakes, latches the winner's opcode and operands, and evaluates them in the ALU. It returns the result and status flags on a single tagged response channel with backpressure. It sits between the lane issue logic and the shared integer ALU.

## Interface
Clocking and reset: one clock; reset is synchronous and active-high.

Parameters:
- `NUM_REQ`, default 4: number of requesters (2..16).
- `ID_W`, default 2: width of the requester index, equal to clog2(`NUM_REQ`).

Ports:
- `clk`, input, 1: single clock; all state updates on its rising edge.
- `rst`, input, 1: reset, synchronous and active-high.
- `req_valid`, input, `NUM_REQ`: bit i set means requester i presents an operation.
- `req_ready`, output, `NUM_REQ`: one-hot grant; a handshake occurs on bit i when `req_valid[i]` and `req_ready[i]` are both high.
- `req_op`, input, 4*`NUM_REQ`: opcode for requester i in slice [4i+3:4i].
- `req_a`, input, 32*`NUM_REQ`: operand A for requester i in slice [32i+31:32i], signed.
- `req_b`, input, 32*`NUM_REQ`: operand B for requester i, same packing, signed.
- `rsp_valid`, output, 1: response present.
- `rsp_ready`, input, 1: consumer accepts the response.
- `rsp_id`, output, `ID_W`: index of the requester that owns the response.
- `rsp_result`, output, 32: ALU result.
- `rsp_flags`, output, 5: ALU flags, packed as {ZF, NF, EF, GF, LF}.
- `rsp_err`, output, 1: the opcode was outside 0..9; `rsp_result` is 0.
- `busy`, output, 1: high whenever the state is not IDLE.

## Operation
- FSM has three states: IDLE, EXEC and RESP.
- In IDLE, if any `req_valid` bit is set, the round-robin picker chooses the first valid requester at or after `rr_ptr`, wrapping modulo `NUM_REQ`.
  - The winner's `req_ready` bit is driven high combinationally in the same cycle.
  - The winner's op, A, B and id are latched into operand registers, and the FSM moves to EXEC.
  - `rr_ptr` updates to (winner + 1) mod `NUM_REQ`.
- In EXEC, the ALU evaluates the latched operands. Result, flags and `rsp_err` are registered into the response registers, `rsp_valid` is set, and the FSM moves to RESP.
- In RESP, `rsp_*` outputs hold stable while `rsp_valid` is high and `rsp_ready` is low.
  - On a response handshake with any `req_valid` set: grant the next winner in the same cycle and move to EXEC (back-to-back issue).
  - On a response handshake with no `req_valid` set: clear `rsp_valid` and move to IDLE.
- `req_ready` is all-zero in EXEC, and in RESP when `rsp_ready` is low.
- Opcodes: 0 ADD, 1 SUB, 2 SL, 3 SR, 4 AND, 5 OR, 6 XOR, 7 NAND, 8 NOT, 9 NOR.
  - Opcodes 10..15 are forwarded to the ALU, which yields result 0, and set `rsp_err` = 1.
- Arithmetic is 32-bit and wraps with no carry out.
- Shift amount is B taken as unsigned. SR is a logical shift.
- GF and LF are signed comparisons of A and B. EF means result == A.
- Requesters must hold `req_valid`, op and operands stable until granted. Deasserting `req_valid` before the grant withdraws the request without error.

## Timing
- Reset values: state IDLE, `rr_ptr` 0, `rsp_valid` 0, `rsp_id` 0, `rsp_result` 0, `rsp_flags` 0, `rsp_err` 0, `busy` 0, `req_ready` 0.
- Latency: a grant in cycle N gives `rsp_valid` high from cycle N+2.
- Throughput: one operation per 2 cycles with `rsp_ready` held high.
- `rst` mid-operation: the in-flight operation and any pending response are discarded. All outputs take reset values on the next edge, and no grant is issued in the reset cycle.
- Simultaneous requests: exactly one grant per handshake cycle; there is no starvation, since the worst-case wait is `NUM_REQ`-1 other grants.
- Wrap-around: when the winner is `NUM_REQ`-1, `rr_ptr` returns to 0.
- Indefinite backpressure: with `rsp_ready` low, the block stays in RESP and grants nothing.

## Structure
- Package `alu_pkg` holds:
  - the opcode localparams (0..9);
  - `OP_W` = 4 and `FLAG_W` = 5;
  - flag bit indices ZF=4, NF=3, EF=2, GF=1, LF=0;
  - the FSM state enum.
- Sub-module `rr_arbiter`: inputs are the valid vector and `rr_ptr`; outputs are a one-hot grant, the winner index and an any-valid signal. It is purely combinational.
- The existing ALU is instantiated once and fed only from the operand registers.

## Test plan
- Single request, requester 2, SUB, A=5, B=7 → `req_ready` = 0b0100 in the grant cycle; two cycles later `rsp_id`=2, `rsp_result`=0xFFFFFFFE, LF=1, GF=0, ZF=0.
- All four requesters valid and held, `rsp_ready`=1 → grant order 0,1,2,3,0, one grant every 2 cycles; each `rsp_id` matches its grant.
- ADD, A=0x7FFFFFFF, B=1 → `rsp_result`=0x80000000; XOR, A=B=0x1234 → result 0, ZF=1.
- Opcode 12 from requester 1 → `rsp_result`=0, `rsp_err`=1, `rsp_id`=1.
- `rsp_ready` held low for 5 cycles with other requests pending → `rsp_*` stable and `req_ready`=0 throughout; the next grant occurs in the handshake cycle.
- `rst` asserted in EXEC → next cycle `rsp_valid`=0, `busy`=0, `rr_ptr`=0; the next request from requester 0 is granted first.
